// File: rtl/imem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter_if
//   Bundles the three buses around the instruction-memory arbiter: the core
//   fetch port (read-only), the host load/readback port (read/write) and the
//   single-port memory interface.
//
//   Signals (direction seen from the arbiter, i.e. the slave modport):
//     core_req_valid  in   core fetch request
//     core_req_addr   in   core fetch word address
//     core_req_ready  out  core request accepted this cycle
//     core_rsp_valid  out  core read data valid
//     core_rsp_data   out  core read data
//     host_req_valid  in   host request
//     host_req_we     in   1 = write, 0 = read
//     host_req_addr   in   host word address
//     host_req_wdata  in   host write data
//     host_req_ready  out  host request accepted this cycle
//     host_rsp_valid  out  host read data valid (reads only)
//     host_rsp_data   out  host read data
//     mem_en          out  memory access strobe
//     mem_we          out  memory write enable
//     mem_addr        out  memory word address
//     mem_wdata       out  memory write data
//     mem_rdata       in   memory read data, one cycle after a read strobe
//
//   Modports:
//     slave  - the arbiter
//     master - the requesters and memory model surrounding it
// -----------------------------------------------------------------------------
interface imem_port_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              core_req_valid;
   logic [ADDR_W-1:0] core_req_addr;
   logic              core_req_ready;
   logic              core_rsp_valid;
   logic [DATA_W-1:0] core_rsp_data;

   logic              host_req_valid;
   logic              host_req_we;
   logic [ADDR_W-1:0] host_req_addr;
   logic [DATA_W-1:0] host_req_wdata;
   logic              host_req_ready;
   logic              host_rsp_valid;
   logic [DATA_W-1:0] host_rsp_data;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req_valid, core_req_addr,
      input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
      input  mem_rdata,
      output core_req_ready, core_rsp_valid, core_rsp_data,
      output host_req_ready, host_rsp_valid, host_rsp_data,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output core_req_valid, core_req_addr,
      output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
      output mem_rdata,
      input  core_req_ready, core_rsp_valid, core_rsp_data,
      input  host_req_ready, host_rsp_valid, host_rsp_data,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//   Shares one single-port synchronous instruction memory between the core
//   fetch port and a host load/readback port. Round-robin between the two
//   eligible requesters, with a host lock that shuts the core out during
//   program loading. Read data returns exactly one cycle after the grant.
//   A saturating counter records cycles in which both ports competed.
//
//   Ports:
//     clk           in   clock, rising edge
//     reset         in   synchronous, active-high
//     host_lock     in   1 = core is never granted
//     conflict_cnt  out  saturating count of cycles with both ports eligible
//     bus           imem_port_arbiter_if.slave (core, host and memory buses)
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               host_lock,
   output logic [CNT_W-1:0]   conflict_cnt,
   imem_port_arbiter_if.slave bus
);

   // Which port won the most recent grant; steers the next tie-break.
   typedef enum logic {
      GRANT_CORE = 1'b0,
      GRANT_HOST = 1'b1
   } grant_e;

   // Grant decision for the current cycle.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_CORE = 2'd1,
      SEL_HOST = 2'd2
   } sel_e;

   grant_e            r_last_grant;
   grant_e            w_last_grant_nxt;
   sel_e              w_sel;

   logic              w_core_elig;
   logic              w_host_elig;
   logic              w_conflict;

   logic              w_core_ready;
   logic              w_host_ready;
   logic              w_mem_en;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   logic              w_core_xfer;
   logic              w_host_rd_xfer;

   logic              r_core_rsp_valid;
   logic              r_host_rsp_valid;
   logic [CNT_W-1:0]  r_conflict_cnt;

   // ---------------------------------------------------------------------------
   // Eligibility. The lock masks the core entirely, so a locked core neither
   // wins nor counts as a conflict.
   // ---------------------------------------------------------------------------
   assign w_core_elig = bus.core_req_valid & ~host_lock;
   assign w_host_elig = bus.host_req_valid;
   assign w_conflict  = w_core_elig & w_host_elig;

   // ---------------------------------------------------------------------------
   // Grant selection: a lone eligible port always wins; on a tie the port that
   // did not win last time goes first. Nothing is granted while in reset, so a
   // write presented during reset never reaches the memory.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_sel = SEL_NONE;
      if (!reset) begin
         if (w_conflict)
            w_sel = (r_last_grant == GRANT_HOST) ? SEL_CORE : SEL_HOST;
         else if (w_core_elig)
            w_sel = SEL_CORE;
         else if (w_host_elig)
            w_sel = SEL_HOST;
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin state: register, next-state and output processes.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of block order.
      if (reset)
         r_last_grant <= GRANT_HOST;
      else
         r_last_grant <= w_last_grant_nxt;
   end

   always_comb begin
      w_last_grant_nxt = r_last_grant;
      case (w_sel)
         SEL_CORE: w_last_grant_nxt = GRANT_CORE;
         SEL_HOST: w_last_grant_nxt = GRANT_HOST;
         default:  w_last_grant_nxt = r_last_grant;
      endcase
   end

   always_comb begin
      w_core_ready = 1'b0;
      w_host_ready = 1'b0;
      w_mem_en     = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_addr   = '0;
      w_mem_wdata  = '0;
      case (w_sel)
         SEL_CORE: begin
            w_core_ready = 1'b1;
            w_mem_en     = 1'b1;
            w_mem_addr   = bus.core_req_addr;
         end
         SEL_HOST: begin
            w_host_ready = 1'b1;
            w_mem_en     = 1'b1;
            w_mem_we     = bus.host_req_we;
            w_mem_addr   = bus.host_req_addr;
            w_mem_wdata  = bus.host_req_wdata;
         end
         default: ;
      endcase
   end

   assign bus.core_req_ready = w_core_ready;
   assign bus.host_req_ready = w_host_ready;
   assign bus.mem_en         = w_mem_en;
   assign bus.mem_we         = w_mem_we;
   assign bus.mem_addr       = w_mem_addr;
   assign bus.mem_wdata      = w_mem_wdata;

   // ---------------------------------------------------------------------------
   // Response path: the memory returns data one cycle after a read strobe, so
   // a one-cycle valid flag per port tags whose data is on mem_rdata. Host
   // writes produce no response.
   // ---------------------------------------------------------------------------
   assign w_core_xfer    = bus.core_req_valid & w_core_ready;
   assign w_host_rd_xfer = bus.host_req_valid & w_host_ready & ~bus.host_req_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_core_rsp_valid <= 1'b0;
         r_host_rsp_valid <= 1'b0;
      end else begin
         r_core_rsp_valid <= w_core_xfer;
         r_host_rsp_valid <= w_host_rd_xfer;
      end
   end

   assign bus.core_rsp_valid = r_core_rsp_valid;
   assign bus.host_rsp_valid = r_host_rsp_valid;
   assign bus.core_rsp_data  = r_core_rsp_valid ? bus.mem_rdata : '0;
   assign bus.host_rsp_data  = r_host_rsp_valid ? bus.mem_rdata : '0;

   // ---------------------------------------------------------------------------
   // Conflict counter: sticks at all-ones instead of wrapping.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset)
         r_conflict_cnt <= '0;
      else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}}))
         r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
   end

   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_port_arbiter
//   Drives the arbiter with directed scenarios followed by random traffic.
//   A behavioural model (grant rule, memory contents, response queue and
//   counters) predicts every output each cycle; a few directed steps pin the
//   model with hand-computed values. A second instance with a 2-bit counter
//   shares all inputs to exercise saturation.
// -----------------------------------------------------------------------------
module tb_imem_port_arbiter;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_lock;
   logic [15:0] cnt;
   logic [1:0]  cnt_sat;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   imem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   imem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_sat ();

   imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .host_lock    (host_lock),
      .conflict_cnt (cnt),
      .bus          (bus)
   );

   imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
      .clk          (clk),
      .reset        (reset),
      .host_lock    (host_lock),
      .conflict_cnt (cnt_sat),
      .bus          (bus_sat)
   );

   // The saturation instance sees exactly the same requests and memory data.
   assign bus_sat.core_req_valid = bus.core_req_valid;
   assign bus_sat.core_req_addr  = bus.core_req_addr;
   assign bus_sat.host_req_valid = bus.host_req_valid;
   assign bus_sat.host_req_we    = bus.host_req_we;
   assign bus_sat.host_req_addr  = bus.host_req_addr;
   assign bus_sat.host_req_wdata = bus.host_req_wdata;
   assign bus_sat.mem_rdata      = bus.mem_rdata;

   always #5 clk = ~clk;

   // Single-port synchronous memory driven by the DUT.
   logic [DATA_W-1:0] tb_mem [DEPTH];
   always @(posedge clk) begin
      if (bus.mem_en === 1'b1) begin
         if (bus.mem_we === 1'b1) tb_mem[bus.mem_addr] <= bus.mem_wdata;
         else                     bus.mem_rdata <= tb_mem[bus.mem_addr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: who has priority on a tie, what the memory holds, what
   // response is owed next cycle, and the two counters.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] model_mem [DEPTH];
   bit                m_core_turn  = 1'b1;   // after reset the host counts as last winner
   bit                m_core_rsp_v = 1'b0;
   bit                m_host_rsp_v = 1'b0;
   logic [DATA_W-1:0] m_core_rsp_d = '0;
   logic [DATA_W-1:0] m_host_rsp_d = '0;
   int                m_cnt        = 0;
   int                m_cnt_sat    = 0;
   bit                ce, he, gc, gh, conf;

   always @(negedge clk) begin
      if (chk_en) begin
         ce   = bus.core_req_valid && !host_lock && !reset;
         he   = bus.host_req_valid && !reset;
         gc   = ce && (!he || m_core_turn);
         gh   = he && !gc;
         conf = bus.core_req_valid && !host_lock && bus.host_req_valid;

         check("core_ready", bus.core_req_ready, gc);
         check("host_ready", bus.host_req_ready, gh);
         check("mem_en",     bus.mem_en,         gc || gh);
         check("sat_mem_en", bus_sat.mem_en,     gc || gh);
         if (gc) begin
            check("mem_we_core",   bus.mem_we,   1'b0);
            check("mem_addr_core", bus.mem_addr, bus.core_req_addr);
         end
         if (gh) begin
            check("mem_we_host",   bus.mem_we,   bus.host_req_we);
            check("mem_addr_host", bus.mem_addr, bus.host_req_addr);
            if (bus.host_req_we) check("mem_wdata", bus.mem_wdata, bus.host_req_wdata);
         end
         check("core_rsp_valid", bus.core_rsp_valid, m_core_rsp_v);
         check("core_rsp_data",  bus.core_rsp_data,  m_core_rsp_v ? m_core_rsp_d : '0);
         check("host_rsp_valid", bus.host_rsp_valid, m_host_rsp_v);
         check("host_rsp_data",  bus.host_rsp_data,  m_host_rsp_v ? m_host_rsp_d : '0);
         check("conflict_cnt",   cnt,     m_cnt);
         check("conflict_sat",   cnt_sat, m_cnt_sat);

         // Advance the model to what the coming rising edge produces.
         if (reset) begin
            m_core_turn  = 1'b1;
            m_core_rsp_v = 1'b0;
            m_host_rsp_v = 1'b0;
            m_cnt        = 0;
            m_cnt_sat    = 0;
         end else begin
            if (gc) m_core_turn = 1'b0;
            if (gh) m_core_turn = 1'b1;
            m_core_rsp_v = gc;
            m_core_rsp_d = model_mem[bus.core_req_addr];
            m_host_rsp_v = gh && !bus.host_req_we;
            m_host_rsp_d = model_mem[bus.host_req_addr];
            if (gh && bus.host_req_we) model_mem[bus.host_req_addr] = bus.host_req_wdata;
            if (conf) begin
               if (m_cnt < 65535) m_cnt++;
               if (m_cnt_sat < 3) m_cnt_sat++;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic drive(input logic rst, input logic lock,
                        input logic cv, input logic [ADDR_W-1:0] ca,
                        input logic hv, input logic hwe, input logic [ADDR_W-1:0] ha,
                        input logic [DATA_W-1:0] hd);
      reset              = rst;
      host_lock          = lock;
      bus.core_req_valid = cv;
      bus.core_req_addr  = ca;
      bus.host_req_valid = hv;
      bus.host_req_we    = hwe;
      bus.host_req_addr  = ha;
      bus.host_req_wdata = hd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] exp_core_win;
      exp_core_win = 5'b10101;   // bit k: core wins conflict cycle k after reset

      for (int i = 0; i < DEPTH; i++) begin
         logic [DATA_W-1:0] w;
         w = $urandom;
         tb_mem[i]    = w;
         model_mem[i] = w;
      end
      tb_mem[3]     = 32'h00500093;
      model_mem[3]  = 32'h00500093;
      bus.mem_rdata = '0;

      // Reset for two cycles with every request asserted.
      drive(1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, '0);
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_core_ready", bus.core_req_ready, 1'b0);
      check("rst_host_ready", bus.host_req_ready, 1'b0);
      check("rst_mem_en",     bus.mem_en,         1'b0);
      check("rst_core_rsp",   bus.core_rsp_valid, 1'b0);
      check("rst_host_rsp",   bus.host_rsp_valid, 1'b0);
      check("rst_cnt",        cnt,                16'd0);

      // Lone core read of address 3.
      drive(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 6'd0, '0);
      #1 check("t2_core_ready", bus.core_req_ready, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, '0);
      check("t2_rsp_valid", bus.core_rsp_valid, 1'b1);
      check("t2_rsp_data",  bus.core_rsp_data,  32'h00500093);
      tick();

      // Continuous conflict after reset: strict alternation starting with core.
      drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, '0);
      tick();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 1'b1, 6'(10 + k), 1'b1, 1'b0, 6'(20 + k), '0);
         #1;
         check("t3_core_ready", bus.core_req_ready, exp_core_win[k]);
         check("t3_host_ready", bus.host_req_ready, !exp_core_win[k]);
         tick();
         check("t3_core_rsp", bus.core_rsp_valid, exp_core_win[k]);
         check("t3_host_rsp", bus.host_rsp_valid, !exp_core_win[k]);
         if (k == 3) check("t3_cnt4", cnt, 16'd4);
      end
      check("t3_cnt5",    cnt,     16'd5);
      check("t6_cnt_sat", cnt_sat, 2'd3);

      // Host loads addresses 0..3 under lock while the core keeps asking.
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 6'(k), 32'hA000_0000 + k);
         #1;
         check("t4_core_ready", bus.core_req_ready, 1'b0);
         check("t4_mem_we",     bus.mem_we,         1'b1);
         tick();
      end
      check("t4_cnt_held", cnt, 16'd5);
      drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 6'd0, '0);
      #1 check("t4_unlock_ready", bus.core_req_ready, 1'b1);
      tick();

      // Host write immediately followed by a core read of the same word.
      drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
      tick();
      drive(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 6'd0, '0);
      tick();
      check("t5_rsp_valid", bus.core_rsp_valid, 1'b1);
      check("t5_rsp_data",  bus.core_rsp_data,  32'hDEADBEEF);

      // Reset right after a core grant drops the pending response.
      drive(1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 6'd6, 32'h1234_5678);
      #1 check("t6_rst_mem_en", bus.mem_en, 1'b0);
      tick();
      check("t6_rsp_dropped", bus.core_rsp_valid, 1'b0);
      check("t6_cnt_clear",   cnt,                16'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 99) == 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) != 0,
               6'($urandom),
               $urandom_range(0, 2) != 0,
               $urandom_range(0, 2) == 0,
               6'($urandom),
               $urandom);
         tick();
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
